regfile_write_buffer: RTL and testbench

- Small write-back queue sitting directly upstream of the 32x32 register file's single write port.
- Accepts register writes from the datapath via a valid/ready handshake and holds them in a FIFO.
- Drains one entry per cycle into the register file's wrenable/write-register/write-data inputs whenever the port is granted.
- Optionally exposes a pending-write lookup so reads can see queued data not yet committed.

---
 rtl/regfile_write_buffer.sv | 173 +++++++++++++++++
 tb/tb_regfile_write_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer
//
// Write-back queue in front of the 32x32 register file's single write port.
// The datapath pushes register writes with a valid/ready handshake. Each
// cycle that the write port is granted, one entry drains into the register
// file in push order. Writes to register 0 complete the handshake but are
// dropped, because register 0 is hard-wired to zero.
//
// Optional feature (macro WBUF_BYPASS_EN):
//   When this macro is defined, a combinational lookup reports whether any
//   pending entry targets rd_addr. If so, it returns the data of the youngest
//   matching entry. When the macro is undefined, rd_hit and rd_data are tied
//   to 0 and no comparators are built.
//
// Parameters:
//   DEPTH  FIFO entries (power of 2, >= 2)
//   AW     register address width
//   DW     data width
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   upstream write request
//   in_ready   buffer can accept (== !full)
//   in_addr    destination register of the incoming write
//   in_data    incoming write data
//   drain_en   register-file write port granted this cycle
//   wrenable   write strobe to the register file
//   writereg   head entry address
//   writedata  head entry data
//   rd_addr    lookup address
//   rd_hit     a pending entry targets rd_addr
//   rd_data    data of the youngest matching pending entry
//   count      occupied entries
//   empty      count == 0
//   full       count == DEPTH
module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  output logic                     wrenable,
  output logic [AW-1:0]            writereg,
  output logic [DW-1:0]            writedata,
  input  logic [AW-1:0]            rd_addr,
  output logic                     rd_hit,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);  // pointer width
  localparam int CW = PW + 1;         // count width, must be able to hold DEPTH

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];

  logic store;  // accepted push that actually occupies an entry
  logic pop;    // head entry commits to the register file at this edge

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;

  // Gating with reset_n keeps the strobe low in the reset cycle itself, so
  // nothing commits while pending entries are being dropped.
  assign pop      = reset_n && !empty && drain_en;
  assign wrenable = pop;

  // Register 0 is hard-wired to zero. Writes to it are acknowledged but not
  // stored.
  assign store    = in_valid && in_ready && (in_addr != '0);

  assign writereg  = addr_q[head_q];
  assign writedata = data_q[head_q];
  assign count     = count_q;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;

    if (store) begin
      addr_d[tail_q] = in_addr;
      data_d[tail_q] = in_data;
      vld_d[tail_q]  = 1'b1;
      tail_d         = tail_q + PW'(1);
    end

    // A push and a pop in the same cycle never touch the same slot. A push
    // requires the buffer to be non-full and a pop requires it to be
    // non-empty, and in that state tail and head differ.
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end

    unique case ({store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset. The valid bits and
  // count are what mark an entry live, so clearing the payload would only
  // add reset fan-out.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

`ifdef WBUF_BYPASS_EN
  logic [PW-1:0] rd_idx;

  // Walk from oldest to youngest. A later match overwrites an earlier one,
  // so the youngest matching entry wins.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    rd_idx  = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = head_q + PW'(i);
      if (vld_q[rd_idx] && (addr_q[rd_idx] == rd_addr) && (rd_addr != '0)) begin
        rd_hit  = 1'b1;
        rd_data = data_q[rd_idx];
      end
    end
  end
`else
  assign rd_hit  = 1'b0;
  assign rd_data = '0;

  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Self-checking bench for regfile_write_buffer (DEPTH=4, AW=5, DW=32).
// It applies a table of directed vectors, then hand-written multi-cycle
// sequences (streaming with pointer wrap, reset mid-operation, lookup),
// then randomized traffic checked against a queue-based reference model.
module tb_regfile_write_buffer;

  localparam int DEPTH = 4;

`ifdef WBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        wrenable;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [4:0]  rd_addr;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  regfile_write_buffer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .drain_en  (drain_en),
    .wrenable  (wrenable),
    .writereg  (writereg),
    .writedata (writedata),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [4:0] a,
                       input logic [31:0] d, input logic drn, input logic [4:0] ra);
    reset_n  = rst;
    in_valid = vld;
    in_addr  = a;
    in_data  = d;
    drain_en = drn;
    rd_addr  = ra;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One row is one clock cycle. The expectations are the outputs seen
  // before that cycle's rising edge.
  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        drn;
    int          cnt;
    logic        rdy;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] seq_data[10];
    ent_t        mq[$];
    int          exp_cnt;
    logic        exp_we, exp_hit, push;
    logic [31:0] exp_rdata;

    //             rst  vld  addr   data           drn cnt rdy  we   wreg   wdata
    vecs[0]  = '{1'b0, 1'b1, 5'd5, 32'h1,        1'b1, 0, 1'b1, 1'b0, 5'd0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 0, 1'b1, 1'b0, 5'd0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 0, 1'b1, 1'b0, 5'd0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 5'd1, 32'h11,       1'b0, 0, 1'b1, 1'b0, 5'd0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 5'd2, 32'h22,       1'b0, 1, 1'b1, 1'b0, 5'd1, 32'h11};
    vecs[7]  = '{1'b1, 1'b1, 5'd3, 32'h33,       1'b0, 2, 1'b1, 1'b0, 5'd1, 32'h11};
    vecs[8]  = '{1'b1, 1'b1, 5'd4, 32'h44,       1'b0, 3, 1'b1, 1'b0, 5'd1, 32'h11};
    vecs[9]  = '{1'b1, 1'b1, 5'd9, 32'h99,       1'b0, 4, 1'b0, 1'b0, 5'd1, 32'h11};
    vecs[10] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 4, 1'b0, 1'b1, 5'd1, 32'h11};
    vecs[11] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 3, 1'b1, 1'b1, 5'd2, 32'h22};
    vecs[12] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 2, 1'b1, 1'b1, 5'd3, 32'h33};
    vecs[13] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1, 1'b1, 1'b1, 5'd4, 32'h44};
    vecs[14] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 0, 1'b1, 1'b0, 5'd0, 32'h0};
    vecs[15] = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 0, 1'b1, 1'b0, 5'd0, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 0, 1'b1, 1'b0, 5'd0, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 0, 1'b1, 1'b0, 5'd0, 32'h0};

    // First reset cycle: state is still unknown, but the strobe must be low.
    drive(1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd0);
    @(negedge clk);
    check("reset_first_wrenable", 32'(wrenable), 32'd0);
    next_cycle();

    // Directed table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].vld, vecs[i].addr, vecs[i].data, vecs[i].drn, 5'd0);
      @(negedge clk);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].cnt == DEPTH));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      check($sformatf("vec%0d_wrenable", i), 32'(wrenable), 32'(vecs[i].we));
      check($sformatf("vec%0d_rd_hit", i), 32'(rd_hit), 32'd0);
      check($sformatf("vec%0d_rd_data", i), rd_data, 32'd0);
      if (vecs[i].cnt > 0) begin
        check($sformatf("vec%0d_writereg", i), 32'(writereg), 32'(vecs[i].wreg));
        check($sformatf("vec%0d_writedata", i), writedata, vecs[i].wdata);
      end
      next_cycle();
    end

    // Streaming: push and drain every cycle, 10 entries, pointers wrap twice
    for (int k = 0; k < 10; k++) seq_data[k] = $urandom;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, k < 10, 5'(k + 1), (k < 10) ? seq_data[k] : 32'h0, 1'b1, 5'd0);
      @(negedge clk);
      check($sformatf("stream%0d_count", k), 32'(count), (k == 0 || k == 11) ? 32'd0 : 32'd1);
      if (k >= 1 && k <= 10) begin
        check($sformatf("stream%0d_wrenable", k), 32'(wrenable), 32'd1);
        check($sformatf("stream%0d_writereg", k), 32'(writereg), 32'(k));
        check($sformatf("stream%0d_writedata", k), writedata, seq_data[k-1]);
      end else begin
        check($sformatf("stream%0d_wrenable", k), 32'(wrenable), 32'd0);
      end
      next_cycle();
    end

    // Reset while three entries are pending
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 5'(k + 5), 32'h100 + 32'(k), 1'b0, 5'd0);
      next_cycle();
    end
    drive(1'b0, 1'b1, 5'd9, 32'h9, 1'b1, 5'd0);
    @(negedge clk);
    check("midrst_count_before", 32'(count), 32'd3);
    check("midrst_wrenable_in_reset", 32'(wrenable), 32'd0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
      @(negedge clk);
      check($sformatf("midrst%0d_count", k), 32'(count), 32'd0);
      check($sformatf("midrst%0d_wrenable", k), 32'(wrenable), 32'd0);
      next_cycle();
    end

    // Lookup: two pushes to r7, youngest wins; r0 and r8 miss; miss after drain
    drive(1'b1, 1'b1, 5'd7, 32'hAAAA, 1'b0, 5'd7);
    @(negedge clk);
    check("byp_samecycle_hit", 32'(rd_hit), 32'd0);
    next_cycle();
    drive(1'b1, 1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd7);
    @(negedge clk);
    check("byp_one_hit", 32'(rd_hit), 32'(BYP));
    check("byp_one_data", rd_data, BYP ? 32'hAAAA : 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
    @(negedge clk);
    check("byp_two_hit", 32'(rd_hit), 32'(BYP));
    check("byp_two_data", rd_data, BYP ? 32'hBBBB : 32'h0);
    rd_addr = 5'd0;
    #1;
    check("byp_r0_hit", 32'(rd_hit), 32'd0);
    check("byp_r0_data", rd_data, 32'd0);
    rd_addr = 5'd8;
    #1;
    check("byp_r8_hit", 32'(rd_hit), 32'd0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
      @(negedge clk);
      check($sformatf("byp_drain%0d_hit", k), 32'(rd_hit), 32'(BYP));
      check($sformatf("byp_drain%0d_data", k), rd_data, BYP ? 32'hBBBB : 32'h0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
    @(negedge clk);
    check("byp_after_drain_hit", 32'(rd_hit), 32'd0);
    check("byp_after_drain_count", 32'(count), 32'd0);
    next_cycle();

    // Randomized traffic against a queue model of the pending writes
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    next_cycle();
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 8)));
      @(negedge clk);
      exp_cnt = mq.size();
      exp_we  = reset_n && (exp_cnt != 0) && drain_en;
      check("rand_count", 32'(count), 32'(exp_cnt));
      check("rand_full", 32'(full), 32'(exp_cnt == DEPTH));
      check("rand_in_ready", 32'(in_ready), 32'(exp_cnt != DEPTH));
      check("rand_wrenable", 32'(wrenable), 32'(exp_we));
      if (exp_cnt != 0) begin
        check("rand_writereg", 32'(writereg), 32'(mq[0].a));
        check("rand_writedata", writedata, mq[0].d);
      end
      exp_hit   = 1'b0;
      exp_rdata = 32'h0;
      if (BYP && rd_addr != 5'd0) begin
        for (int j = exp_cnt - 1; j >= 0; j--) begin
          if (mq[j].a == rd_addr) begin
            exp_hit   = 1'b1;
            exp_rdata = mq[j].d;
            break;
          end
        end
      end
      check("rand_rd_hit", 32'(rd_hit), 32'(exp_hit));
      check("rand_rd_data", rd_data, exp_rdata);

      if (!reset_n) begin
        mq.delete();
      end else begin
        push = in_valid && (exp_cnt < DEPTH) && (in_addr != 5'd0);
        if (exp_we) void'(mq.pop_front());
        if (push) mq.push_back('{a: in_addr, d: in_data});
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
